// File: rtl/uart_tx_word_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_word_buffer
//
// Takes WORD_WIDTH-bit words from the debug/pipeline UART interface, queues
// them in a small FIFO, and passes each word to the UART transmitter core one
// byte at a time, least-significant byte first.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_word         word to transmit
//   i_word_valid   push request, sampled on the rising edge
//   o_buffer_ready FIFO not full (count < depth); combinational from count_q
//   o_tx_data      byte presented to the transmitter (registered)
//   o_tx_start     one-cycle pulse requesting transmission of o_tx_data
//   i_tx_done      one-cycle pulse from the transmitter after the stop bit
//   o_idle         FIFO empty and FSM in IDLE
//   o_overflow     sticky; a push was attempted while full
//   o_dbg_state    current FSM state, for observation only
//
// Handshakes
//   Producer side: a word transfers on a rising edge where i_word_valid=1 and
//   o_buffer_ready=1. If i_word_valid=1 while o_buffer_ready=0, the word is
//   dropped and o_overflow latches.
//   Transmitter side: o_tx_start pulses for exactly one cycle with o_tx_data
//   valid. o_tx_data then holds until the matching i_tx_done pulse. An
//   i_tx_done seen while o_tx_start is high is not counted as completion.
// ---------------------------------------------------------------------------
module uart_tx_word_buffer #(
    parameter int WORD_WIDTH     = 32,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic                  i_word_valid,
    output logic                  o_buffer_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_idle,
    output logic                  o_overflow,
    output logic [1:0]            o_dbg_state
);

    localparam int BYTES  = WORD_WIDTH / 8;
    localparam int DEPTH  = 1 << FIFO_ADDR_BITS;
    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [FIFO_ADDR_BITS:0] DEPTH_CNT = (FIFO_ADDR_BITS + 1)'(DEPTH);
    localparam logic [FIFO_ADDR_BITS:0] CNT_ONE   = (FIFO_ADDR_BITS + 1)'(1);
    localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE = FIFO_ADDR_BITS'(1);
    localparam logic [BCNT_W-1:0] LAST_BYTE       = BCNT_W'(BYTES - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE        = BCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_START     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_BITS:0]   count_q, count_d;
    logic [BCNT_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [WORD_WIDTH-1:0]     shift_q, shift_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      overflow_q, overflow_d;

    logic [WORD_WIDTH-1:0]     mem_q [DEPTH];

    // -----------------------------------------------------------------------
    // Control decodes
    // -----------------------------------------------------------------------
    logic not_full;
    logic push;
    logic push_rejected;
    logic pop;
    logic byte_done;
    logic byte_advance;

    always_comb begin
        not_full      = (count_q < DEPTH_CNT);
        push          = i_word_valid && not_full;
        // Fullness is judged on the pre-edge count, so a push into a full
        // FIFO is rejected even if a pop frees a slot on the same edge.
        push_rejected = i_word_valid && !not_full;
        pop           = (state_q == ST_IDLE) && (count_q != '0);
        byte_done     = (state_q == ST_WAIT_DONE) && i_tx_done;
        byte_advance  = byte_done && (byte_cnt_q != LAST_BYTE);
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_START;
            end
            ST_START: begin
                // Any i_tx_done in this cycle belongs to nothing we started.
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    state_d = (byte_cnt_q == LAST_BYTE) ? ST_IDLE : ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        o_tx_start     = (state_q == ST_START);
        o_idle         = (state_q == ST_IDLE) && (count_q == '0);
        o_buffer_ready = not_full;
        o_tx_data      = tx_data_q;
        o_overflow     = overflow_q;
        o_dbg_state    = state_q;
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, count, overflow flag
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | push_rejected;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Byte serializer: shift register, byte counter, output byte register
    // -----------------------------------------------------------------------
    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        tx_data_d  = tx_data_q;

        if (pop) begin
            shift_d    = mem_q[rd_ptr_q];
            byte_cnt_d = '0;
        end else if (byte_advance) begin
            shift_d    = shift_q >> 8;
            byte_cnt_d = byte_cnt_q + BCNT_ONE;
        end

        // o_tx_data only changes on LOAD, so it is stable through START and
        // the whole WAIT_DONE period.
        if (state_q == ST_LOAD) begin
            tx_data_d = shift_q[7:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage needs no reset: a slot is only read after being written.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_word;
        end
    end

endmodule

// File: tb/tb_uart_tx_word_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_word_buffer
//
// Bench for uart_tx_word_buffer. The expected byte stream is a queue filled
// from every word the producer pushes (LSB first). A simple transmitter model
// answers each start pulse with a done pulse after a chosen delay. Every DUT
// output is sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_word_buffer;

    logic        clk;
    logic        i_reset;
    logic [31:0] i_word;
    logic        i_word_valid;
    logic        o_buffer_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_idle;
    logic        o_overflow;
    logic [1:0]  o_dbg_state;

    uart_tx_word_buffer #(
        .WORD_WIDTH     (32),
        .FIFO_ADDR_BITS (2)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_word         (i_word),
        .i_word_valid   (i_word_valid),
        .o_buffer_ready (o_buffer_ready),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .i_tx_done      (i_tx_done),
        .o_idle         (o_idle),
        .o_overflow     (o_overflow),
        .o_dbg_state    (o_dbg_state)
    );

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -----------------------------------------------------------------------
    // Scoreboard and bookkeeping
    // -----------------------------------------------------------------------
    logic [7:0] exp_q[$];
    int n_checks;
    int n_pass;
    int cyc;
    int n_starts;
    int done_cyc;
    int word_start_cyc;
    int byte_idx;
    int timer;
    int resp_delay;
    bit resp_en;
    bit early_mode;
    bit force_done;
    bit prev_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: wait for the falling edge, observe the transmitter
    // side, then drive the transmitter model's done line for the next edge.
    task automatic tick();
        logic [7:0] exp_byte;
        @(negedge clk);
        cyc++;
        if (o_tx_start) begin
            check("no_back_to_back_start", prev_start, 1'b0);
            check("start_before_done", timer, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_byte", o_tx_data, 32'hxxxx_xx00);
            end else begin
                exp_byte = exp_q.pop_front();
                check("tx_byte", o_tx_data, exp_byte);
            end
            if (byte_idx != 0) begin
                check("byte_gap", cyc - done_cyc, 2);
            end else begin
                word_start_cyc = cyc;
            end
            byte_idx = (byte_idx + 1) % 4;
            n_starts++;
        end
        prev_start = o_tx_start;

        i_tx_done = 1'b0;
        if (force_done) begin
            i_tx_done  = 1'b1;
            force_done = 1'b0;
            done_cyc   = cyc;
        end else if (timer > 0) begin
            timer--;
            if (timer == 0) begin
                i_tx_done = 1'b1;
                done_cyc  = cyc;
            end
        end
        if (o_tx_start && resp_en) begin
            timer = resp_delay;
            if (early_mode) begin
                i_tx_done = 1'b1;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic push_word(input logic [31:0] w, input bit expect_accept);
        i_word       = w;
        i_word_valid = 1'b1;
        if (expect_accept) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
            end
        end
        tick();
        i_word_valid = 1'b0;
    endtask

    task automatic push_gated(input logic [31:0] w);
        int guard;
        guard = 0;
        while (!o_buffer_ready && guard < 400) begin
            tick();
            guard++;
        end
        check("ready_wait", o_buffer_ready, 1'b1);
        push_word(w, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        tick();
        while (!(o_idle && exp_q.size() == 0 && timer == 0) && guard < 2000) begin
            tick();
            guard++;
        end
        check(tag, o_idle, 1'b1);
        check({tag, "_exp_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, o_tx_data, 8'h00);
        check({tag, "_tx_start"}, o_tx_start, 1'b0);
        check({tag, "_ready"}, o_buffer_ready, 1'b1);
        check({tag, "_idle"}, o_idle, 1'b1);
        check({tag, "_overflow"}, o_overflow, 1'b0);
        check({tag, "_state"}, o_dbg_state, 2'd0);
    endtask

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int base;
        int guard;
        logic [31:0] w[5];
        logic [31:0] rw;

        n_checks = 0; n_pass = 0; cyc = 0; n_starts = 0;
        done_cyc = 0; word_start_cyc = 0; byte_idx = 0; timer = 0;
        resp_delay = 10; resp_en = 1'b1; early_mode = 1'b0;
        force_done = 1'b0; prev_start = 1'b0;
        i_reset = 1'b1; i_word = '0; i_word_valid = 1'b0; i_tx_done = 1'b0;

        // Reset state
        tick();
        check_reset_outputs("reset");
        i_reset = 1'b0;
        tick();
        tick();
        check_reset_outputs("after_reset");

        // Single word, done 10 cycles after each start
        base = n_starts;
        resp_delay = 10;
        begin
            int push_cyc;
            push_cyc = cyc;
            push_word(32'h4433_2211, 1'b1);
            wait_drain("single_drain");
            check("single_latency", word_start_cyc - push_cyc, 3);
        end
        check("single_starts", n_starts - base, 4);

        // Burst into a full FIFO with done held low
        base = n_starts;
        resp_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("burst_ready", o_buffer_ready, (i < 5) ? 1'b1 : 1'b0);
            push_word(32'hA0 + i, i < 5);
        end
        check("burst_overflow", o_overflow, 1'b1);
        check("burst_full", o_buffer_ready, 1'b0);
        tick();
        force_done = 1'b1;
        resp_en = 1'b1;
        resp_delay = 3;
        wait_drain("burst_drain");
        check("burst_starts", n_starts - base, 20);
        check("overflow_sticky", o_overflow, 1'b1);

        // Wrap-around: 10 words, producer gated by ready
        base = n_starts;
        resp_delay = 2;
        for (int i = 0; i < 10; i++) begin
            push_gated(i);
        end
        wait_drain("wrap_drain");
        check("wrap_starts", n_starts - base, 40);

        // Concurrent push/pop: the second push lands on the first word's pop
        // edge, so exactly three more pushes should fit before full.
        base = n_starts;
        resp_en = 1'b0;
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        push_word(w[0], 1'b1);
        push_word(w[1], 1'b1);
        for (int i = 2; i < 5; i++) begin
            check("conc_ready", o_buffer_ready, 1'b1);
            push_word(w[i], 1'b1);
        end
        check("conc_full", o_buffer_ready, 1'b0);
        force_done = 1'b1;
        resp_en = 1'b1;
        resp_delay = $urandom_range(1, 6);
        wait_drain("conc_drain");
        check("conc_starts", n_starts - base, 20);

        // Start-cycle done: every start also gets a done in the START cycle
        base = n_starts;
        early_mode = 1'b1;
        resp_delay = $urandom_range(1, 8);
        push_gated($urandom);
        push_gated($urandom);
        wait_drain("early_drain");
        check("early_starts", n_starts - base, 8);
        early_mode = 1'b0;

        // Random words, gaps and transmitter delays
        base = n_starts;
        for (int i = 0; i < 16; i++) begin
            resp_delay = $urandom_range(1, 12);
            rw = $urandom;
            if ((i % 5) == 0) rw = 32'hFFFF_FFFF;
            push_gated(rw);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain("random_drain");
        check("random_starts", n_starts - base, 64);

        // Reset mid-word with two words queued behind it
        base = n_starts;
        resp_en = 1'b1;
        resp_delay = 6;
        push_word(32'hDEAD_BEEF, 1'b1);
        push_word($urandom, 1'b1);
        push_word($urandom, 1'b1);
        guard = 0;
        while (n_starts < base + 2 && guard < 200) begin
            tick();
            guard++;
        end
        check("reset_mid_reached", n_starts - base, 2);
        i_reset = 1'b1;
        #1;
        check("reset_start_async", o_tx_start, 1'b0);
        exp_q.delete();
        byte_idx = 0;
        tick();
        tick();
        check_reset_outputs("mid_reset");
        i_reset = 1'b0;
        base = n_starts;
        repeat (15) tick();
        check("reset_no_start", n_starts - base, 0);
        check("reset_late_done_idle", o_idle, 1'b1);
        check("reset_clears_overflow", o_overflow, 1'b0);
        resp_delay = 4;
        push_word(32'hFFFF_FFFF, 1'b1);
        wait_drain("marker_drain");
        check("marker_starts", n_starts - base, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
